// File: rtl/uart_pkg.sv
// Shared definitions for the uart_par block: engine state encodings, parity
// mode constants and the parity helper used by both RX and TX.
package uart_pkg;

    localparam int MAX_DBIT = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    // Words narrower than MAX_DBIT are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DBIT-1:0] data,
                                        input logic par_odd);
        return (^data) ^ (par_odd == PAR_ODD);
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO: full writes are dropped unless a read frees a slot in the
// same cycle; reads of an empty FIFO are ignored.
module fifo #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem_q [2**W];
    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         wr_en;
    logic         rd_en;

    assign rd_en = rd & ~empty_q;
    assign wr_en = wr & (~full_q | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        case ({wr_en, rd_en})
            2'b01: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_q + 1'b1) == wr_ptr_q;
            end
            2'b10: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_q + 1'b1) == rd_ptr_q;
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign empty  = empty_q;
    assign full   = full_q;
    assign r_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_par.sv
// UART receiver with 16x oversampling, optional parity check and stop-bit check.
// state    | meaning
// ST_IDLE  | line idle, waiting for a 0
// ST_START | start bit, confirmed at mid-bit (tick 7) or rejected as glitch
// ST_DATA  | DBIT data samples, LSB first
// ST_PAR   | parity sample (only with PARITY_EN)
// ST_STOP  | stop period; done pulse and error report at its end
module uart_rx_par
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int PARITY_EN = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx_i,
    input  logic            s_tick_i,
    input  logic            par_odd_i,
    output logic            rx_done_o,
    output logic [DBIT-1:0] dout_o,
    output logic            par_err_o,
    output logic            frame_err_o
);

    localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);

    uart_state_e     state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            pbit_q, pbit_d;
    logic            rx_meta_q, rx_sync_q;

    // Two-flop synchroniser; the pin is asynchronous to clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        pbit_d      = pbit_q;
        rx_done_o   = 1'b0;
        par_err_o   = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                end
            end
            ST_START: begin
                if (s_tick_i) begin
                    if (s_q == 5'd7) begin
                        if (rx_sync_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick_i) begin
                    if (s_q == 5'd15) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == BIT_LAST) begin
                            state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_PAR: begin
                if (s_tick_i) begin
                    if (s_q == 5'd15) begin
                        s_d     = '0;
                        pbit_d  = rx_sync_q;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (s_tick_i) begin
                    if (s_q == SB_LAST) begin
                        state_d     = ST_IDLE;
                        rx_done_o   = 1'b1;
                        frame_err_o = ~rx_sync_q;
                        par_err_o   = (PARITY_EN != 0) &&
                                      (pbit_q != parity_bit(8'(b_q), par_odd_i));
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            pbit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            pbit_q  <= pbit_d;
        end
    end

    assign dout_o = b_q;

endmodule

// File: rtl/uart_par.sv
// UART top: baud tick generator, TX engine, RX engine, one FIFO per direction
// and the sticky parity/framing/overrun flags.
// state    | meaning (TX engine)
// ST_IDLE  | tx=1, waiting for a word in the TX FIFO
// ST_START | start bit, 16 ticks
// ST_DATA  | DBIT data bits, LSB first, 16 ticks each
// ST_PAR   | parity bit (only with PARITY_EN)
// ST_STOP  | stop period, SB_TICK ticks; leaving pops the TX FIFO
module uart_par
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR_BIT  = 11,
    parameter int FIFO_W    = 2,
    parameter int PARITY_EN = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic                par_odd,
    input  logic                rx,
    input  logic                rd_uart,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                clr_err,
    output logic                tx,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                rx_full,
    output logic                tx_full,
    output logic                par_err,
    output logic                frame_err,
    output logic                ovr_err
);

    localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);

    logic [DVSR_BIT-1:0] dvsr_eff;
    logic [DVSR_BIT-1:0] cnt_q, cnt_d;
    logic                baud_tick;

    // Down-counter reloads from dvsr only at terminal count, so a new divisor
    // takes effect on the following period.
    assign dvsr_eff  = (dvsr == '0) ? DVSR_BIT'(1) : dvsr;
    assign baud_tick = (cnt_q == '0);
    assign cnt_d     = baud_tick ? (dvsr_eff - DVSR_BIT'(1)) : (cnt_q - DVSR_BIT'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    logic            rx_done;
    logic [DBIT-1:0] rx_word;
    logic            rx_perr;
    logic            rx_ferr;

    uart_rx_par #(
        .DBIT      (DBIT),
        .SB_TICK   (SB_TICK),
        .PARITY_EN (PARITY_EN)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_i        (rx),
        .s_tick_i    (baud_tick),
        .par_odd_i   (par_odd),
        .rx_done_o   (rx_done),
        .dout_o      (rx_word),
        .par_err_o   (rx_perr),
        .frame_err_o (rx_ferr)
    );

    fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .rd      (rd_uart),
        .wr      (rx_done & ~rx_full),
        .w_data  (rx_word),
        .empty   (rx_empty),
        .full    (rx_full),
        .r_data  (r_data)
    );

    logic            tx_empty;
    logic            tx_done;
    logic [DBIT-1:0] tx_head;

    fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .rd      (tx_done),
        .wr      (wr_uart),
        .w_data  (w_data),
        .empty   (tx_empty),
        .full    (tx_full),
        .r_data  (tx_head)
    );

    uart_state_e     tx_state_q, tx_state_d;
    logic [4:0]      tx_s_q, tx_s_d;
    logic [2:0]      tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_par_q, tx_par_d;
    logic            tx_q, tx_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_par_d   = tx_par_q;
        tx_done    = 1'b0;
        tx_d       = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_state_d = ST_START;
                    tx_s_d     = '0;
                    tx_b_d     = tx_head;
                    tx_par_d   = parity_bit(8'(tx_head), par_odd);
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    if (tx_s_q == 5'd15) begin
                        tx_state_d = ST_DATA;
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (tx_s_q == 5'd15) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == BIT_LAST) begin
                            tx_state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
                        end else begin
                            tx_n_d = tx_n_q + 3'd1;
                        end
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            ST_PAR: begin
                if (baud_tick) begin
                    if (tx_s_q == 5'd15) begin
                        tx_state_d = ST_STOP;
                        tx_s_d     = '0;
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (tx_s_q == SB_LAST) begin
                        tx_state_d = ST_IDLE;
                        tx_done    = 1'b1;
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // Line level follows the next state so tx is a clean register output.
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_b_d[0];
            ST_PAR:   tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= ST_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

    logic par_err_q, par_err_d;
    logic frame_err_q, frame_err_d;
    logic ovr_err_q, ovr_err_d;

    // A set event in the same cycle as clr_err wins.
    assign par_err_d   = rx_perr | (par_err_q & ~clr_err);
    assign frame_err_d = rx_ferr | (frame_err_q & ~clr_err);
    assign ovr_err_d   = (rx_done & rx_full) | (ovr_err_q & ~clr_err);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign ovr_err   = ovr_err_q;

endmodule
